// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: data width plus the read-FSM state and owner types shared by the
// memory read arbiter files.
package mem_arb_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_LSU} arb_owner_e;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, LSU and memory-side signals of the arbiter; slave is the
// arbiter's view, master is the requester/memory side.
interface mem_arb_if;
    logic flush;
    logic if_req_valid, if_req_ready, if_resp_valid;
    logic [mem_arb_pkg::XLEN-1:0] if_req_addr, if_resp_data;
    logic lsu_rd_valid, lsu_rd_ready, lsu_resp_valid;
    logic [mem_arb_pkg::XLEN-1:0] lsu_rd_addr, lsu_resp_data;
    logic lsu_wr_valid;
    logic [mem_arb_pkg::XLEN-1:0] lsu_wr_addr, lsu_wr_data;
    logic mem_rd_valid, mem_rd_resp;
    logic [mem_arb_pkg::XLEN-1:0] mem_rd_addr, mem_rd_data;
    logic mem_wr_valid;
    logic [mem_arb_pkg::XLEN-1:0] mem_wr_addr, mem_wr_data;
    modport slave (
        input  flush, if_req_valid, if_req_addr, lsu_rd_valid, lsu_rd_addr,
        input  lsu_wr_valid, lsu_wr_addr, lsu_wr_data, mem_rd_resp, mem_rd_data,
        output if_req_ready, if_resp_valid, if_resp_data, lsu_rd_ready, lsu_resp_valid,
        output lsu_resp_data, mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
    modport master (
        output flush, if_req_valid, if_req_addr, lsu_rd_valid, lsu_rd_addr,
        output lsu_wr_valid, lsu_wr_addr, lsu_wr_data, mem_rd_resp, mem_rd_data,
        input  if_req_ready, if_resp_valid, if_resp_data, lsu_rd_ready, lsu_resp_valid,
        input  lsu_resp_data, mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of contested LSU grants; hit forces the
// next contested grant to fetch.
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(STARVE_MAX + 1);
    logic [W-1:0] cnt;
    assign hit = cnt == W'(STARVE_MAX);
    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : (inc && !hit) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares the memory read port between fetch and LSU loads with one read
// outstanding, and forwards committed stores to the write port one cycle later.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rst,
    mem_arb_if.slave bus
);
    arb_state_e state, state_next;
    arb_owner_e owner;
    logic [XLEN-1:0] addr, wr_addr, wr_data;
    logic wr_valid, drop, starve_hit, idle, if_ok, free, grant_if, grant_lsu, resp_hit;
    logic if_ready, lsu_ready, rd_valid, if_resp, lsu_resp;

    assign idle = state == ARB_IDLE;
    assign if_ok = bus.if_req_valid && !bus.flush;
    // a same-cycle store must reach memory before any read is issued
    assign free = idle && !bus.lsu_wr_valid;
    assign grant_if = free && if_ok && (!bus.lsu_rd_valid || starve_hit);
    assign grant_lsu = free && bus.lsu_rd_valid && !(if_ok && starve_hit);
    assign resp_hit = !idle && bus.mem_rd_resp;

    mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(grant_lsu && if_ok),
        .clr(grant_if || (idle && !bus.if_req_valid)),
        .hit(starve_hit)
    );

    always_ff @(posedge clk)
        state <= rst ? ARB_IDLE : state_next;

    always_comb
        state_next = idle ? ((grant_if || grant_lsu) ? ARB_REQ : ARB_IDLE)
                          : (resp_hit ? ARB_IDLE : ARB_WAIT);

    always_comb begin
        if_ready = grant_if;
        lsu_ready = grant_lsu;
        rd_valid = state == ARB_REQ;
        if_resp = resp_hit && owner == OWN_IF && !drop && !bus.flush;
        lsu_resp = resp_hit && owner == OWN_LSU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            owner <= OWN_IF;
            drop <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (grant_if || grant_lsu) begin
                addr <= grant_lsu ? bus.lsu_rd_addr : bus.if_req_addr;
                owner <= grant_lsu ? OWN_LSU : OWN_IF;
            end
            // sticky squash of an in-flight fetch; released when the read retires
            drop <= !idle && !resp_hit && (drop || bus.flush);
            wr_valid <= bus.lsu_wr_valid;
            wr_addr <= bus.lsu_wr_addr;
            wr_data <= bus.lsu_wr_data;
        end
    end

    assign bus.if_req_ready = if_ready;
    assign bus.lsu_rd_ready = lsu_ready;
    assign bus.if_resp_valid = if_resp;
    assign bus.lsu_resp_valid = lsu_resp;
    assign bus.if_resp_data = if_resp ? bus.mem_rd_data : '0;
    assign bus.lsu_resp_data = lsu_resp ? bus.mem_rd_data : '0;
    assign bus.mem_rd_valid = rd_valid;
    assign bus.mem_rd_addr = addr;
    assign bus.mem_wr_valid = wr_valid;
    assign bus.mem_wr_addr = wr_addr;
    assign bus.mem_wr_data = wr_data;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: transaction-level model of the arbiter checked against the DUT every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arb;
    localparam int SM = 4;
    logic clk = 1'b0, rst;
    mem_arb_if bus();
    mem_arb #(.STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit started = 0;
    bit m_busy, m_own_if, m_drop, m_wv;
    int m_age, m_starve;
    logic [31:0] m_addr, m_wa, m_wd;
    int lat;
    bit auto_r, spur;
    logic [31:0] rdata;
    bit gr[10];
    int ng;
    bit exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // 0 = no grant, 1 = fetch, 2 = load
    function automatic int winner();
        bit if_ok = bus.if_req_valid && !bus.flush;
        if (m_busy || bus.lsu_wr_valid) return 0;
        if (bus.lsu_rd_valid && if_ok) return (m_starve >= SM) ? 1 : 2;
        if (bus.lsu_rd_valid) return 2;
        return if_ok ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner();
        started = 1;
        if (rst) begin
            m_busy = 0; m_drop = 0; m_starve = 0; m_addr = 0; m_age = 0;
            m_wv = 0; m_wa = 0; m_wd = 0; m_own_if = 0;
        end else begin
            m_wv = bus.lsu_wr_valid; m_wa = bus.lsu_wr_addr; m_wd = bus.lsu_wr_data;
            if (m_busy) begin
                if (bus.mem_rd_resp) begin m_busy = 0; m_drop = 0; end
                else begin m_drop = m_drop || bus.flush; m_age++; end
            end else begin
                if (w == 1) m_starve = 0;
                else if (w == 2 && bus.if_req_valid && !bus.flush) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
                else if (!bus.if_req_valid) m_starve = 0;
                if (w != 0) begin
                    m_busy = 1; m_own_if = (w == 1); m_age = 1; m_drop = 0;
                    m_addr = (w == 1) ? bus.if_req_addr : bus.lsu_rd_addr;
                end
            end
        end
    end

    always @(negedge clk) if (started) begin
        int w;
        bit got, ifr, lsr;
        w = winner();
        got = m_busy && bus.mem_rd_resp;
        ifr = got && m_own_if && !m_drop && !bus.flush;
        lsr = got && !m_own_if;
        chk("if_req_ready", bus.if_req_ready, w == 1);
        chk("lsu_rd_ready", bus.lsu_rd_ready, w == 2);
        chk("mem_rd_valid", bus.mem_rd_valid, m_busy && m_age == 1);
        chk("mem_rd_addr", bus.mem_rd_addr, m_addr);
        chk("if_resp_valid", bus.if_resp_valid, ifr);
        chk("if_resp_data", bus.if_resp_data, ifr ? bus.mem_rd_data : 32'h0);
        chk("lsu_resp_valid", bus.lsu_resp_valid, lsr);
        chk("lsu_resp_data", bus.lsu_resp_data, lsr ? bus.mem_rd_data : 32'h0);
        chk("mem_wr_valid", bus.mem_wr_valid, m_wv);
        chk("mem_wr_addr", bus.mem_wr_addr, m_wa);
        chk("mem_wr_data", bus.mem_wr_data, m_wd);
    end

    // memory responds lat cycles after the grant (lat=1 is zero-latency)
    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_rd_resp = spur || (auto_r && m_busy && m_age == lat);
        bus.mem_rd_data = bus.mem_rd_resp ? rdata : 32'h0;
    endtask

    task automatic idle_steps(input int n);
        bus.if_req_valid = 0; bus.lsu_rd_valid = 0; bus.lsu_wr_valid = 0; bus.flush = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1; bus.flush = 0;
        bus.if_req_valid = 0; bus.if_req_addr = 0;
        bus.lsu_rd_valid = 0; bus.lsu_rd_addr = 0;
        bus.lsu_wr_valid = 0; bus.lsu_wr_addr = 0; bus.lsu_wr_data = 0;
        bus.mem_rd_resp = 0; bus.mem_rd_data = 0;
        lat = 2; auto_r = 1; spur = 0; rdata = 0;
        step(); step();
        @(negedge clk);
        chk("rst_mem_rd_valid", bus.mem_rd_valid, 0);
        chk("rst_mem_wr_valid", bus.mem_wr_valid, 0);
        chk("rst_mem_rd_addr", bus.mem_rd_addr, 0);
        rst = 0;

        // single load, 2-cycle memory
        step(); rdata = 32'hDEAD; bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h40;
        step();
        bus.mem_rd_resp = 0;
        @(negedge clk);
        idle_steps(1);
        step(); bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h40;
        @(negedge clk); chk("ld_ready", bus.lsu_rd_ready, 1);
        step(); bus.lsu_rd_valid = 0;
        @(negedge clk); chk("ld_mem_rd_valid", bus.mem_rd_valid, 1); chk("ld_mem_rd_addr", bus.mem_rd_addr, 32'h40);
        step();
        @(negedge clk);
        chk("ld_resp_valid", bus.lsu_resp_valid, 1);
        chk("ld_resp_data", bus.lsu_resp_data, 32'hDEAD);
        chk("ld_if_resp_valid", bus.if_resp_valid, 0);
        idle_steps(2);

        // contention with zero-latency memory
        lat = 1; rdata = 32'hC0DE; bus.if_req_addr = 32'h200; bus.lsu_rd_addr = 32'h300; ng = 0;
        for (int c = 0; c < 24; c++) begin
            step(); bus.if_req_valid = 1; bus.lsu_rd_valid = 1;
            @(negedge clk);
            if (ng < 10 && (bus.if_req_ready || bus.lsu_rd_ready)) begin gr[ng] = bus.if_req_ready; ng++; end
        end
        idle_steps(3);
        chk("grant_count", ng, 10);
        for (int i = 0; i < 10; i++) chk($sformatf("grant_%0d", i), gr[i], exp_g[i]);

        // zero-latency: response in the REQ cycle, next grant right after
        rdata = 32'h77;
        step(); bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h20;
        @(negedge clk); chk("zl_ready", bus.lsu_rd_ready, 1);
        step(); bus.lsu_rd_addr = 32'h24;
        @(negedge clk);
        chk("zl_mem_rd_valid", bus.mem_rd_valid, 1);
        chk("zl_resp_valid", bus.lsu_resp_valid, 1);
        chk("zl_resp_data", bus.lsu_resp_data, 32'h77);
        chk("zl_busy_ready", bus.lsu_rd_ready, 0);
        step();
        @(negedge clk); chk("zl_b2b_ready", bus.lsu_rd_ready, 1);
        idle_steps(3);

        // flush during WAIT squashes the fetch response
        lat = 3; rdata = 32'h1234;
        step(); bus.if_req_valid = 1; bus.if_req_addr = 32'h100;
        @(negedge clk); chk("fl_if_ready", bus.if_req_ready, 1);
        step(); bus.if_req_valid = 0;
        step(); bus.flush = 1;
        step(); bus.flush = 0; bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h44;
        @(negedge clk);
        chk("fl_if_resp_valid", bus.if_resp_valid, 0);
        chk("fl_lsu_ready_busy", bus.lsu_rd_ready, 0);
        step();
        @(negedge clk); chk("fl_next_grant", bus.lsu_rd_ready, 1);
        idle_steps(5);

        // store and load to the same address in one cycle
        lat = 2;
        step(); bus.lsu_wr_valid = 1; bus.lsu_wr_addr = 32'h80; bus.lsu_wr_data = 32'h55;
        bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h80;
        @(negedge clk); chk("st_rd_blocked", bus.lsu_rd_ready, 0);
        step(); bus.lsu_wr_valid = 0;
        @(negedge clk);
        chk("st_wr_valid", bus.mem_wr_valid, 1);
        chk("st_wr_addr", bus.mem_wr_addr, 32'h80);
        chk("st_wr_data", bus.mem_wr_data, 32'h55);
        chk("st_rd_granted", bus.lsu_rd_ready, 1);
        step(); bus.lsu_rd_valid = 0;
        @(negedge clk); chk("st_wr_pulse", bus.mem_wr_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(); bus.lsu_wr_valid = 1; bus.lsu_wr_addr = 32'h90 + i; bus.lsu_wr_data = 32'hA0 + i;
        end
        idle_steps(3);

        // reset while a read is outstanding, then a stray response
        lat = 5;
        step(); bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h60;
        @(negedge clk); chk("rw_ready", bus.lsu_rd_ready, 1);
        step(); bus.lsu_rd_valid = 0;
        step(); rst = 1;
        spur = 1; auto_r = 0; rdata = 32'hBAD;
        step(); rst = 0;
        @(negedge clk);
        chk("rw_lsu_resp", bus.lsu_resp_valid, 0);
        chk("rw_if_resp", bus.if_resp_valid, 0);
        chk("rw_mem_rd_valid", bus.mem_rd_valid, 0);
        chk("rw_mem_rd_addr", bus.mem_rd_addr, 0);
        chk("rw_lsu_resp_data", bus.lsu_resp_data, 0);
        spur = 0; auto_r = 1;
        step(); bus.lsu_rd_valid = 1; bus.lsu_rd_addr = 32'h64;
        @(negedge clk); chk("rw_idle_grant", bus.lsu_rd_ready, 1);
        idle_steps(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
